// File: rtl/ahb5_pkg.sv
// Shared AHB5 encodings and helpers for the subordinate models.
package ahb5_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sub_state_e;

  // Little-endian byte lanes touched by a 2^hsize-byte transfer at addr_lsbs.
  function automatic logic [7:0] lane_mask(input logic [2:0] addr_lsbs,
                                           input logic [2:0] hsize,
                                           input int unsigned nbytes);
    logic [7:0]  m;
    int unsigned lo;
    int unsigned hi;
    m  = '0;
    lo = 32'(addr_lsbs);
    hi = lo + (32'd1 << hsize);
    for (int unsigned i = 0; i < 8; i++) begin
      m[i] = (i >= lo) && (i < hi) && (i < nbytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/ahb5_wait_ctr.sv
// Loadable down-counter with a done flag for wait-state insertion.
module ahb5_wait_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);

  assign done = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !done) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/ahb5_sram_subordinate.sv
// AHB5 SRAM subordinate: word memory, programmable wait states, byte-lane
// writes with HWSTRB and an address window that answers with two-cycle ERROR.
module ahb5_sram_subordinate
  import ahb5_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 256,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] ERR_LO      = 32'hFFFF_FF00,
  parameter logic [ADDR_W-1:0] ERR_HI      = 32'hFFFF_FFFF
) (
  input  logic                Hclk,
  input  logic                HReset,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic [DATA_W/8-1:0] HWSTRB,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [DATA_W-1:0]   HRDATA
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned BL      = $clog2(NB);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sub_state_e        state, nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     idx_q, a_idx, rd_idx;
  logic [2:0]        lsbs_q, size_q;
  logic              write_q;
  logic              accept, take, err, wr_en, rd_load, fwd;
  logic              ctr_load, ctr_en, ctr_done;
  logic [3:0]        unused_count;
  logic [NB-1:0]     lm, be;
  logic [DATA_W-1:0] wr_word, rd_word;
  logic              unused_ok;

  assign unused_ok = &{1'b0, HBURST};

  always_comb begin
    accept = HSEL && HREADY && (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);
    take   = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
    a_idx  = HADDR[BL +: AW];
    err    = (HADDR >= ERR_LO && HADDR <= ERR_HI)
          || ((HADDR >> BL) >= ADDR_W'(DEPTH))
          || (HSIZE > 3'(BL))
          || (|(HADDR[6:0] & ~(7'h7F << HSIZE)));

    lm      = NB'(lane_mask(lsbs_q, size_q, NB));
    be      = HWSTRB & lm;
    wr_en   = (state == ST_DATA) && HREADY && write_q;
    wr_word = mem[idx_q];
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end

    // A zero-wait read accepted while the previous write completes must see
    // that write's merged word, since memory only updates at this same edge.
    rd_idx  = take ? a_idx : idx_q;
    fwd     = wr_en && (idx_q == rd_idx);
    rd_word = fwd ? wr_word : mem[rd_idx];
    rd_load = (take && !err && !HWRITE && WAIT_STATES == 0)
           || (state == ST_WAIT && ctr_done && !write_q);

    nxt = state;
    case (state)
      ST_WAIT: if (ctr_done) nxt = ST_DATA;
      ST_ERR1: nxt = ST_ERR2;
      default: begin
        if (HREADY) begin
          if (take) nxt = err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);
          else      nxt = ST_IDLE;
        end
      end
    endcase

    ctr_load = (nxt == ST_WAIT) && (state != ST_WAIT);
    ctr_en   = (state == ST_WAIT);
  end

  ahb5_wait_ctr #(.W(4)) u_wait_ctr (
    .clk      (Hclk),
    .rst      (HReset),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (WS_LOAD),
    .count    (unused_count),
    .done     (ctr_done)
  );

  always_ff @(posedge Hclk or posedge HReset) begin
    if (HReset) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
      HRDATA    <= '0;
      idx_q     <= '0;
      lsbs_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      state     <= nxt;
      HREADYOUT <= !(nxt == ST_WAIT || nxt == ST_ERR1);
      HRESP     <= (nxt == ST_ERR1 || nxt == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
      if (take) begin
        idx_q   <= a_idx;
        lsbs_q  <= 3'(HADDR[BL-1:0]);
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
      if (nxt == ST_ERR1) HRDATA <= '0;
      else if (rd_load)   HRDATA <= rd_word;
    end
  end

  always_ff @(posedge Hclk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb5_sram_subordinate.sv
// Scoreboard bench: three subordinates with 0, 1 and 2 wait states checked
// against a byte-level memory model of the AHB5 SRAM behaviour.
module tb_ahb5_sram_subordinate;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel [3];
  logic [31:0] haddr [3];
  logic [1:0]  htrans [3];
  logic        hwrite [3];
  logic [2:0]  hsize [3];
  logic [2:0]  hburst [3];
  logic [31:0] hwdata [3];
  logic [3:0]  hwstrb [3];
  logic        hreadyout [3];
  logic        hresp [3];
  logic [31:0] hrdata [3];

  int          checks = 0;
  int          passed = 0;
  int          act = 0;
  exp_t        sbq[$];
  logic [31:0] mref [int];
  logic [31:0] pend_wd [3];
  logic [3:0]  pend_st [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb5_sram_subordinate #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH       (256),
      .WAIT_STATES (g)
    ) u_dut (
      .Hclk      (clk),
      .HReset    (rst),
      .HSEL      (hsel[g]),
      .HADDR     (haddr[g]),
      .HTRANS    (htrans[g]),
      .HWRITE    (hwrite[g]),
      .HSIZE     (hsize[g]),
      .HBURST    (hburst[g]),
      .HWDATA    (hwdata[g]),
      .HWSTRB    (hwstrb[g]),
      .HREADY    (hreadyout[g]),
      .HREADYOUT (hreadyout[g]),
      .HRESP     (hresp[g]),
      .HRDATA    (hrdata[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [2:0] sz);
    return (a >= 32'hFFFF_FF00 && a <= 32'hFFFF_FFFF) || (a / 4 >= 256)
        || (sz > 2) || (a % (32'd1 << sz) != 0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] a, input logic [2:0] sz,
                                        input logic [3:0] st);
    logic [31:0] r;
    int          lo;
    r  = old;
    lo = int'(a % 4);
    for (int k = 0; k < 4; k++) begin
      if (k >= lo && k < lo + (1 << sz) && st[k]) r[8*k +: 8] = wd[8*k +: 8];
    end
    return r;
  endfunction

  // One address phase; the previous transfer's write data rides along with it.
  task automatic xfer(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [3:0] st);
    int   n;
    int   key;
    exp_t e;
    hsel[d]   = sel;
    htrans[d] = tr;
    haddr[d]  = a;
    hwrite[d] = wr;
    hsize[d]  = sz;
    hburst[d] = 3'd0;
    hwdata[d] = pend_wd[d];
    hwstrb[d] = pend_st[d];
    @(negedge clk);
    n = 0;
    while (!hreadyout[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!hreadyout[d]) begin
      checks++;
      $display("FAIL hready_timeout: got %b expected 1", hreadyout[d]);
    end
    if (sel && tr[1]) begin
      e.err   = model_err(a, sz);
      e.rd    = !wr;
      e.waits = e.err ? 1 : d;
      e.data  = '0;
      if (!e.err) begin
        key = d * 4096 + int'(a >> 2);
        if (wr) mref[key] = merge(mref[key], wd, a, sz, st);
        else    e.data = mref[key];
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    pend_wd[d] = wd;
    pend_st[d] = st;
  endtask

  initial begin : monitor
    logic dp;
    int   stalls;
    logic s_or, s_and;
    exp_t e;
    dp = 1'b0; stalls = 0; s_or = 1'b0; s_and = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp = 1'b0;
      end else begin
        if (dp) begin
          if (!hreadyout[act]) begin
            stalls++;
            s_or  = s_or | hresp[act];
            s_and = s_and & hresp[act];
          end else begin
            dp = 1'b0;
            if (sbq.size() == 0) begin
              checks++;
              $display("FAIL unexpected_data_phase: got 1 expected 0");
            end else begin
              e = sbq.pop_front();
              chk("hresp", {31'b0, hresp[act]}, {31'b0, e.err});
              chk("stall_cycles", 32'(stalls), 32'(e.waits));
              if (stalls > 0) chk("stall_hresp", {31'b0, e.err ? s_and : s_or}, {31'b0, e.err});
              if (e.rd || e.err) chk(e.err ? "err_hrdata" : "hrdata", hrdata[act], e.data);
            end
          end
        end
        if (hsel[act] && hreadyout[act] && htrans[act][1]) begin
          dp = 1'b1; stalls = 0; s_or = 1'b0; s_and = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0]  tr;
    logic [31:0] a;
    logic [2:0]  sz;
    int          r;
    for (int d = 0; d < 3; d++) begin
      hsel[d] = 1'b0; htrans[d] = 2'd0; haddr[d] = '0; hwrite[d] = 1'b0;
      hsize[d] = 3'd0; hburst[d] = 3'd0; hwdata[d] = '0; hwstrb[d] = '0;
      pend_wd[d] = '0; pend_st[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_hreadyout", {31'b0, hreadyout[d]}, 32'd1);
      chk("rst_hresp", {31'b0, hresp[d]}, 32'd0);
      chk("rst_hrdata", hrdata[d], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int d = 0; d < 3; d++) begin
      act = d;
      for (int w = 0; w < 64; w++) xfer(d, 1, 2'd2, 1, 32'(w * 4), 3'd2, $urandom, 4'hF);
      xfer(d, 1, 2'd2, 1, 32'h10, 3'd2, 32'hDEAD_BEEF, 4'hF);
      xfer(d, 1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 4'h0);
      xfer(d, 1, 2'd2, 1, 32'h10, 3'd2, 32'h1122_3344, 4'hF);
      xfer(d, 1, 2'd2, 1, 32'h13, 3'd0, 32'hAA00_0000, 4'hF);
      xfer(d, 1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 4'h0);
      xfer(d, 1, 2'd2, 1, 32'hFFFF_FF04, 3'd2, 32'h1234_5678, 4'hF);
      xfer(d, 1, 2'd2, 0, 32'h02, 3'd2, 32'h0, 4'h0);
      xfer(d, 1, 2'd2, 1, 32'h400, 3'd2, 32'hCAFE_F00D, 4'hF);
      xfer(d, 1, 2'd2, 0, 32'h00, 3'd2, 32'h0, 4'h0);
      xfer(d, 1, 2'd2, 0, 32'h04, 3'd3, 32'h0, 4'h0);
      xfer(d, 1, 2'd2, 0, 32'h04, 3'd2, 32'h0, 4'h0);
      for (int k = 0; k < 4; k++)
        xfer(d, 1, (k == 0) ? 2'd2 : 2'd3, 1, 32'(32'h20 + 4 * k), 3'd2, 32'(k + 1), 4'hF);
      for (int k = 0; k < 4; k++)
        xfer(d, 1, (k == 0) ? 2'd2 : 2'd3, 0, 32'(32'h20 + 4 * k), 3'd2, 32'h0, 4'h0);
      for (int n = 0; n < 120; n++) begin
        r  = int'($urandom_range(0, 7));
        tr = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 5) ? 2'd2 : 2'd3;
        a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
        sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        xfer(d, $urandom_range(0, 9) != 0, tr, 1'($urandom), a, sz, $urandom,
             4'($urandom_range(0, 15)));
      end
      xfer(d, 1, 2'd0, 0, 32'h0, 3'd0, 32'h0, 4'h0);
      hsel[d] = 1'b0;
    end

    act = 2;
    hsel[2] = 1'b1; htrans[2] = 2'd2; haddr[2] = 32'h40; hwrite[2] = 1'b1; hsize[2] = 3'd2;
    @(negedge clk);
    @(posedge clk);
    #1;
    hsel[2] = 1'b0; htrans[2] = 2'd0; hwdata[2] = 32'h5555_AAAA; hwstrb[2] = 4'hF;
    chk("wait_entered", {31'b0, hreadyout[2]}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midwait_rst_hreadyout", {31'b0, hreadyout[2]}, 32'd1);
    chk("midwait_rst_hresp", {31'b0, hresp[2]}, 32'd0);
    chk("midwait_rst_hrdata", hrdata[2], 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    xfer(2, 1, 2'd2, 0, 32'h40, 3'd2, 32'h0, 4'h0);
    xfer(2, 1, 2'd0, 0, 32'h0, 3'd0, 32'h0, 4'h0);
    hsel[2] = 1'b0;

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ahb5_sram_subordinate.md
Name: ahb5_sram_subordinate

Overview:
- Parametrised AHB5 subordinate with an internal word-addressed memory, programmable wait states, narrow-transfer byte lanes with HWSTRB, and an error-injection address window.
- Sits on the bus next to the AHB5 master VIP as its default target. It replaces the fixed-behaviour stub so that bursts, wait states and two-cycle ERROR responses can be exercised against the master.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width; legal values 32 or 64.
- DEPTH, 256, memory depth in DATA_W-bit words.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted into every OKAY data phase (0..15).
- ERR_LO, 32'hFFFF_FF00, first byte address of the error window.
- ERR_HI, 32'hFFFF_FFFF, last byte address of the error window.

Ports:
- Hclk  in  1  bus clock; all state changes on its rising edge.
- HReset  in  1  asynchronous, active-high reset.
- HSEL  in  1  subordinate select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of the byte count.
- HBURST  in  3  burst type; informational only, no behaviour depends on it.
- HWDATA  in  DATA_W  write data, valid in the data phase.
- HWSTRB  in  DATA_W/8  write byte strobes, valid in the data phase.
- HREADY  in  1  bus ready (mux output).
- HREADYOUT  out  1  subordinate ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_W  read data.

Behaviour:
- Clock and reset: one clock, Hclk. Reset is asynchronous and active-high on HReset.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
  - Any captured address phase is discarded and a pending write is dropped.
  - Memory contents are not cleared.
- Address-phase accept: a transfer is accepted when HSEL && HREADY && HTRANS[1]. On accept, HADDR, HWRITE and HSIZE are registered.
- IDLE and BUSY transfers are not accepted. Their data phase is zero-wait OKAY, with no memory access.
- Error check on accept. A transfer is an error if any of the following holds:
  - HADDR lies within [ERR_LO, ERR_HI];
  - word index HADDR/(DATA_W/8) >= DEPTH;
  - HSIZE > log2(DATA_W/8);
  - HADDR is not aligned to 2^HSIZE.
- FSM states and transitions:
  - IDLE: HREADYOUT=1, HRESP=0. Good accept → WAIT_STATES>0 ? WAIT : DATA. Error accept → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle. A new accept in the same cycle follows the IDLE rules (pipelined back-to-back). Otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept follows the IDLE rules, because the master may cancel by driving IDLE. Otherwise → IDLE.
- Write:
  - Memory is updated at the rising edge that ends DATA.
  - Effective byte enable = HWSTRB AND the lane mask.
  - The lane mask covers 2^HSIZE bytes starting at byte HADDR[log2(DATA_W/8)-1:0] (little-endian).
  - No write is ever performed for ERR transfers.
- Read:
  - HRDATA carries the full addressed word during DATA and holds its value otherwise.
  - A read whose data phase directly follows a write to the same word returns the newly written bytes (forwarding is required when WAIT_STATES=0).
  - HRDATA is 0 during ERR1/ERR2.
- HREADY low with HSEL high in IDLE or DATA (another subordinate is stalling): no accept occurs and the state does not change.
- Reset asserted mid-WAIT or mid-ERR1: the outputs return to reset values asynchronously and there is no memory side effect.

Decomposition:
- Add to ahb5_pkg:
  - enums htrans_e and hresp_e;
  - hsize_e (BYTE=0, HALF=1, WORD=2, DWORD=3);
  - FSM enum sub_state_e {IDLE, WAIT, DATA, ERR1, ERR2};
  - function lane_mask(addr_lsbs, hsize, nbytes).
- One sub-module, ahb5_wait_ctr: a loadable down-counter with a done flag, reused by future subordinate models.

Test Plan:
- WAIT_STATES=0, DATA_W=32:
  - NONSEQ WORD write 0xDEADBEEF at 0x10, then immediate read at 0x10 → HRDATA=0xDEADBEEF in the read data phase;
  - HREADYOUT never low.
- WAIT_STATES=2: a single read → HREADYOUT low for exactly 2 cycles, then high with HRESP=0.
- Byte write 0xAA at 0x13 with HWSTRB=4'hF over word 0x11223344 → word reads 0xAA223344.
- Error transfers, each giving ERROR with HREADYOUT 0 then 1, HRESP 1 on both cycles, and the memory word unchanged:
  - write to 0xFFFF_FF04;
  - WORD read at unaligned 0x02;
  - address 0x400 with DEPTH=256.
- 4-beat INCR4 writes at 0x20..0x2C, data 1..4, back-to-back with WAIT_STATES=1 → each beat stalls exactly 1 cycle and all four words read back correctly.
- HReset pulsed during WAIT of a write to 0x40 → HREADYOUT=1 immediately and word 0x40 keeps its old value.
